// File: rtl/apb_ss_guard.sv
// ---------------------------------------------------------------------------
// apb_ss_guard
//
// Protective APB bridge placed between one APB target port of the
// interconnect and a student subsystem's register interface. Each upstream
// transfer is captured, then replayed on the downstream port. A watchdog
// bounds the downstream access phase. Disabled or hung subsystems are
// answered with PSLVERR and a fixed read pattern, so the SoC bus never stalls.
//
// Ports:
//   clk, reset_n        single clock, asynchronous active-low reset
//   s_*                 upstream APB target side (request in, response out)
//   m_*                 downstream APB initiator side (request out, response in)
//   ss_en               subsystem enable, sampled only when a request is captured
//   timeout_o           one-cycle pulse in the response cycle of an aborted access
//   timeout_cnt_o       saturating count of aborted downstream accesses
// ---------------------------------------------------------------------------
module apb_ss_guard #(
  parameter int                 APB_AW         = 32,
  parameter int                 APB_DW         = 32,
  parameter int                 TIMEOUT_CYCLES = 256,
  parameter logic [APB_DW-1:0]  ERR_RDATA      = 32'hBADC_AB1E,
  parameter int                 CNT_W          = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  // upstream request
  input  logic [APB_AW-1:0]     s_paddr,
  input  logic [APB_DW-1:0]     s_pwdata,
  input  logic [APB_DW/8-1:0]   s_pstrb,
  input  logic                  s_pwrite,
  input  logic                  s_psel,
  input  logic                  s_penable,
  // upstream response
  output logic [APB_DW-1:0]     s_prdata,
  output logic                  s_pready,
  output logic                  s_pslverr,
  // downstream request
  output logic [APB_AW-1:0]     m_paddr,
  output logic [APB_DW-1:0]     m_pwdata,
  output logic [APB_DW/8-1:0]   m_pstrb,
  output logic                  m_pwrite,
  output logic                  m_psel,
  output logic                  m_penable,
  // downstream response
  input  logic [APB_DW-1:0]     m_prdata,
  input  logic                  m_pready,
  input  logic                  m_pslverr,
  // control / status
  input  logic                  ss_en,
  output logic                  timeout_o,
  output logic [CNT_W-1:0]      timeout_cnt_o
);

  // Watchdog wide enough to hold TIMEOUT_CYCLES-1.
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    M_SETUP  = 2'd1,
    M_ACCESS = 2'd2,
    RESP     = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [APB_AW-1:0]   paddr_q;
  logic [APB_DW-1:0]   pwdata_q;
  logic [APB_DW/8-1:0] pstrb_q;
  logic                pwrite_q;
  logic [APB_DW-1:0]   rdata_q;
  logic                slverr_q;
  logic                err_q;
  logic [WD_W-1:0]     wdog_q;
  logic                timeout_q;
  logic [CNT_W-1:0]    tcnt_q;

  logic capture;
  logic dn_done;
  logic dn_abort;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and state-decoded outputs. Every output is either a
  // register or a function of state_q plus registers, so there is no
  // combinational path from any s_* or m_* input to an output.
  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    dn_done   = 1'b0;
    dn_abort  = 1'b0;
    m_psel    = 1'b0;
    m_penable = 1'b0;
    s_pready  = 1'b0;
    s_prdata  = '0;
    s_pslverr = 1'b0;

    case (state_q)
      IDLE: begin
        if (s_psel && !s_penable) begin
          capture = 1'b1;
          state_d = ss_en ? M_SETUP : RESP;
        end
      end
      M_SETUP: begin
        m_psel  = 1'b1;
        state_d = M_ACCESS;
      end
      M_ACCESS: begin
        m_psel    = 1'b1;
        m_penable = 1'b1;
        // A ready on the last allowed cycle takes priority over the abort.
        if (m_pready) begin
          dn_done = 1'b1;
          state_d = RESP;
        end else if (wdog_q == WD_LAST) begin
          dn_abort = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        s_pready  = 1'b1;
        s_prdata  = err_q ? ERR_RDATA : rdata_q;
        s_pslverr = slverr_q | err_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture, downstream response capture, watchdog and timeout
  // bookkeeping. The error flag is preset on capture when the subsystem is
  // disabled, and set on watchdog abort.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      pwrite_q  <= 1'b0;
      rdata_q   <= '0;
      slverr_q  <= 1'b0;
      err_q     <= 1'b0;
      wdog_q    <= '0;
      timeout_q <= 1'b0;
      tcnt_q    <= '0;
    end else begin
      timeout_q <= dn_abort;

      if (capture) begin
        paddr_q  <= s_paddr;
        pwdata_q <= s_pwdata;
        pstrb_q  <= s_pstrb;
        pwrite_q <= s_pwrite;
        rdata_q  <= '0;
        slverr_q <= 1'b0;
        err_q    <= !ss_en;
      end

      if (state_q == M_SETUP) begin
        wdog_q <= '0;
      end else if (state_q == M_ACCESS) begin
        wdog_q <= wdog_q + WD_W'(1);
      end

      if (dn_done) begin
        rdata_q  <= m_prdata;
        slverr_q <= m_pslverr;
      end

      if (dn_abort) begin
        err_q <= 1'b1;
        if (tcnt_q != {CNT_W{1'b1}}) begin
          tcnt_q <= tcnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign m_paddr       = paddr_q;
  assign m_pwdata      = pwdata_q;
  assign m_pstrb       = pstrb_q;
  assign m_pwrite      = pwrite_q;
  assign timeout_o     = timeout_q;
  assign timeout_cnt_o = tcnt_q;

endmodule

// File: tb/tb_apb_ss_guard.sv
// ---------------------------------------------------------------------------
// tb_apb_ss_guard
//
// Directed bench for apb_ss_guard with a 4-cycle watchdog. A table of
// transfers is applied one by one; the bench plays the downstream target
// itself, answering after a per-vector number of wait states or never.
// Hand-written sequences cover reset, reset mid-access and counter
// saturation.
// ---------------------------------------------------------------------------
module tb_apb_ss_guard;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;
  localparam int CW = 8;
  localparam logic [31:0] ERR = 32'hBADC_AB1E;

  logic          clk;
  logic          reset_n;
  logic [AW-1:0] s_paddr;
  logic [DW-1:0] s_pwdata;
  logic [3:0]    s_pstrb;
  logic          s_pwrite, s_psel, s_penable;
  logic [DW-1:0] s_prdata;
  logic          s_pready, s_pslverr;
  logic [AW-1:0] m_paddr;
  logic [DW-1:0] m_pwdata;
  logic [3:0]    m_pstrb;
  logic          m_pwrite, m_psel, m_penable;
  logic [DW-1:0] m_prdata;
  logic          m_pready, m_pslverr;
  logic          ss_en;
  logic          timeout_o;
  logic [CW-1:0] timeout_cnt_o;

  apb_ss_guard #(
    .APB_AW(AW), .APB_DW(DW), .TIMEOUT_CYCLES(TO),
    .ERR_RDATA(ERR), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_pstrb(s_pstrb),
    .s_pwrite(s_pwrite), .s_psel(s_psel), .s_penable(s_penable),
    .s_prdata(s_prdata), .s_pready(s_pready), .s_pslverr(s_pslverr),
    .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_pstrb(m_pstrb),
    .m_pwrite(m_pwrite), .m_psel(m_psel), .m_penable(m_penable),
    .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr),
    .ss_en(ss_en), .timeout_o(timeout_o), .timeout_cnt_o(timeout_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ws = downstream wait states before ready; -1 means never ready.
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic        en;
    int          ws;
    logic [31:0] dn_rdata;
    logic        dn_slverr;
    logic [31:0] exp_rdata;
    logic        exp_slverr;
    int          exp_lat;
    int          exp_acc;
    int          exp_to;
  } vec_t;

  vec_t vecs[8];
  int   errors = 0;
  int   checks = 0;
  int   exp_cnt = 0;

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Runs one upstream transfer starting in the current (IDLE) cycle, acting
  // as the downstream target, then checks the observed response and timing.
  task automatic apply_stimulus(input vec_t v, input string tag);
    int          lat = -1;
    int          acc = 0;
    int          to_seen = 0;
    int          first_psel = -1;
    int          first_pen = -1;
    logic        field_ok = 1'b1;
    logic        zero_ok = 1'b1;
    logic        done = 1'b0;
    logic [31:0] got_rdata = '0;
    logic        got_slverr = 1'b0;

    s_psel    = 1'b1;
    s_penable = 1'b0;
    s_pwrite  = v.wr;
    s_paddr   = v.addr;
    s_pwdata  = v.wdata;
    s_pstrb   = v.strb;
    ss_en     = v.en;
    m_pready  = 1'b0;
    m_pslverr = 1'b0;
    m_prdata  = '0;

    for (int c = 1; c <= 40 && !done; c++) begin
      @(posedge clk);
      #1;
      s_penable = 1'b1;
      if (m_psel) begin
        if (first_psel < 0) first_psel = c;
        if (m_paddr !== v.addr || m_pwdata !== v.wdata ||
            m_pstrb !== v.strb || m_pwrite !== v.wr) field_ok = 1'b0;
      end
      if (m_psel && m_penable) begin
        if (first_pen < 0) first_pen = c;
        acc++;
        m_pready  = (v.ws >= 0) && (acc - 1 == v.ws);
        m_prdata  = m_pready ? v.dn_rdata : (32'hDEAD_0000 + 32'(acc));
        m_pslverr = m_pready ? v.dn_slverr : 1'b1;
      end else begin
        m_pready  = 1'b0;
        m_pslverr = 1'b0;
        m_prdata  = '0;
      end
      if (timeout_o) to_seen++;
      if (s_pready) begin
        lat        = c;
        got_rdata  = s_prdata;
        got_slverr = s_pslverr;
        done       = 1'b1;
      end else if (s_prdata !== '0 || s_pslverr !== 1'b0) begin
        zero_ok = 1'b0;
      end
    end

    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s cycle_bound: no s_pready within 40 cycles", tag);
    end

    s_psel    = 1'b0;
    s_penable = 1'b0;
    m_pready  = 1'b0;
    m_pslverr = 1'b0;
    if (v.exp_to != 0 && exp_cnt < 255) exp_cnt++;

    check_output({tag, " latency"},     lat,        v.exp_lat);
    check_output({tag, " rdata"},       got_rdata,  v.exp_rdata);
    check_output({tag, " slverr"},      {31'd0, got_slverr}, {31'd0, v.exp_slverr});
    check_output({tag, " access_cyc"},  acc,        v.exp_acc);
    check_output({tag, " timeout_pls"}, to_seen,    v.exp_to);
    check_output({tag, " first_psel"},  first_psel, v.en ? 1 : -1);
    check_output({tag, " first_pen"},   first_pen,  v.en ? 2 : -1);
    check_output({tag, " m_fields"},    {31'd0, field_ok}, 32'd1);
    check_output({tag, " resp_zero"},   {31'd0, zero_ok},  32'd1);
    check_output({tag, " timeout_cnt"}, {24'd0, timeout_cnt_o}, exp_cnt);

    // Cycle after the response: back in IDLE, pulse gone.
    @(posedge clk);
    #1;
    check_output({tag, " pready_1cyc"}, {31'd0, s_pready},  32'd0);
    check_output({tag, " timeout_1cyc"}, {31'd0, timeout_o}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, " s_prdata"},  s_prdata,               32'd0);
    check_output({tag, " s_pready"},  {31'd0, s_pready},      32'd0);
    check_output({tag, " s_pslverr"}, {31'd0, s_pslverr},     32'd0);
    check_output({tag, " m_psel"},    {31'd0, m_psel},        32'd0);
    check_output({tag, " m_penable"}, {31'd0, m_penable},     32'd0);
    check_output({tag, " m_paddr"},   m_paddr,                32'd0);
    check_output({tag, " m_pwdata"},  m_pwdata,               32'd0);
    check_output({tag, " timeout_o"}, {31'd0, timeout_o},     32'd0);
    check_output({tag, " tcnt"},      {24'd0, timeout_cnt_o}, 32'd0);
  endtask

  initial begin
    //          wr    addr           wdata          strb     en    ws  dn_rdata       dn_err exp_rdata      exp_err lat acc to
    vecs[0] = '{1'b0, 32'h1000_0000, 32'h0,         4'hF,    1'b1,  0, 32'h1234_5678, 1'b0,  32'h1234_5678, 1'b0,   3,  1, 0};
    vecs[1] = '{1'b1, 32'h0105_2004, 32'hA5A5_A5A5, 4'b0011, 1'b1,  3, 32'h0,         1'b0,  32'h0,         1'b0,   6,  4, 0};
    vecs[2] = '{1'b0, 32'h2000_0010, 32'h0,         4'hF,    1'b0,  0, 32'h5555_5555, 1'b0,  ERR,           1'b1,   1,  0, 0};
    vecs[3] = '{1'b0, 32'h3000_0020, 32'h0,         4'hF,    1'b1, -1, 32'h0,         1'b0,  ERR,           1'b1,   6,  4, 1};
    vecs[4] = '{1'b0, 32'h4000_0040, 32'h0,         4'hF,    1'b1,  3, 32'hCAFE_F00D, 1'b1,  32'hCAFE_F00D, 1'b1,   6,  4, 0};
    vecs[5] = '{1'b1, 32'h5000_0004, 32'h0123_4567, 4'b1000, 1'b0,  0, 32'h0,         1'b0,  ERR,           1'b1,   1,  0, 0};
    vecs[6] = '{1'b0, 32'h6000_0008, 32'h0,         4'hF,    1'b1,  1, 32'h0F0F_F0F0, 1'b1,  32'h0F0F_F0F0, 1'b1,   4,  2, 0};
    vecs[7] = '{1'b1, 32'h7000_000C, 32'hFFFF_0000, 4'b0101, 1'b1, -1, 32'h0,         1'b0,  ERR,           1'b1,   6,  4, 1};

    reset_n   = 1'b0;
    s_psel    = 1'b0;
    s_penable = 1'b0;
    s_pwrite  = 1'b0;
    s_paddr   = '0;
    s_pwdata  = '0;
    s_pstrb   = '0;
    ss_en     = 1'b0;
    m_pready  = 1'b0;
    m_pslverr = 1'b0;
    m_prdata  = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven transfers.
    foreach (vecs[i]) begin
      apply_stimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset asserted while the downstream access is stalled.
    s_psel    = 1'b1;
    s_penable = 1'b0;
    s_pwrite  = 1'b1;
    s_paddr   = 32'h0ABC_0000;
    s_pwdata  = 32'h1111_2222;
    s_pstrb   = 4'hF;
    ss_en     = 1'b1;
    @(posedge clk);
    #1;
    s_penable = 1'b1;
    @(posedge clk);
    #1;
    check_output("midrst in_access", {31'd0, m_penable}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("midrst");
    exp_cnt   = 0;
    s_psel    = 1'b0;
    s_penable = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    apply_stimulus(vecs[0], "post_rst");

    // Counter saturation over 300 aborted accesses.
    for (int n = 0; n < 300; n++) begin
      apply_stimulus(vecs[3], $sformatf("sat%0d", n));
    end
    check_output("sat final", {24'd0, timeout_cnt_o}, 32'd255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_ss_guard.md
# apb_ss_guard

Protective APB bridge between one APB target port of the OBI-to-APB interconnect subsystem and a student subsystem's register interface. It re-times each transfer onto the downstream port and is gated by a subsystem enable. A watchdog bounds every downstream access. Disabled or hung subsystems are answered with PSLVERR and a fixed read pattern, so the SoC bus never stalls.

## Interface
Parameters:
- APB_AW, 32, address width
- APB_DW, 32, data width; PSTRB width is APB_DW/8
- TIMEOUT_CYCLES, 256, maximum downstream access-phase cycles; must be ≥1
- ERR_RDATA, 32'hBADC_AB1E, PRDATA returned on any guard-generated error
- CNT_W, 8, width of the timeout event counter

Ports (the clock is `clk`; the reset is `reset_n`, asynchronous, active-low):
- clk  in  1  single clock
- reset_n  in  1  asynchronous active-low reset
- s_paddr / s_pwdata / s_pstrb / s_pwrite / s_psel / s_penable  in  APB_AW / APB_DW / APB_DW/8 / 1 / 1 / 1  upstream APB request
- s_prdata / s_pready / s_pslverr  out  APB_DW / 1 / 1  upstream APB response
- m_paddr / m_pwdata / m_pstrb / m_pwrite / m_psel / m_penable  out  same widths  downstream APB request
- m_prdata / m_pready / m_pslverr  in  APB_DW / 1 / 1  downstream APB response
- ss_en  in  1  subsystem enable from SS_Ctrl
- timeout_o  out  1  one-cycle pulse when a downstream access is aborted
- timeout_cnt_o  out  CNT_W  saturating count of aborted accesses

## Operation
- Reset values: all outputs 0, timeout counter 0, FSM in IDLE.
- FSM states: IDLE, M_SETUP, M_ACCESS, RESP.
- **IDLE**
  - When s_psel=1 and s_penable=0, capture paddr, pwdata, pstrb and pwrite into the request registers.
  - If ss_en=1, go to M_SETUP.
  - Otherwise, go to RESP with the error flag set and no downstream access.
- **M_SETUP**: m_psel=1, m_penable=0 for exactly one cycle. Clear the watchdog counter. Go to M_ACCESS.
- **M_ACCESS**
  - m_psel=1, m_penable=1. The watchdog increments each cycle.
  - If m_pready=1: capture m_prdata and m_pslverr, go to RESP.
  - Else if the watchdog equals TIMEOUT_CYCLES-1: drop m_psel/m_penable next cycle, set the error flag, pulse timeout_o, increment timeout_cnt_o (saturating at all-ones), go to RESP.
  - m_pready on the final allowed cycle wins over the timeout.
- **RESP**
  - s_pready=1 for exactly one cycle.
  - s_prdata = captured data, or ERR_RDATA if the error flag is set. ERR_RDATA is also returned on writes that error.
  - s_pslverr = captured m_pslverr OR error flag.
  - Return to IDLE.
- s_prdata and s_pslverr are 0 outside RESP. s_pready is 0 in every state except RESP.
- m_paddr, m_pwdata, m_pstrb and m_pwrite come from the request registers. They are held stable from M_SETUP through the end of M_ACCESS.
- ss_en is sampled only at capture. Deasserting it mid-transfer does not abort the transfer.
- If upstream drops s_psel mid-transfer (protocol violation): the downstream transfer still completes or times out, the RESP cycle still occurs, and the response is discarded. No recovery logic is required.
- The guard never accepts a new request outside IDLE. The RESP→IDLE cycle cannot capture, which gives back-to-back transfers a minimum spacing.
- Reset asserted mid-transfer: immediate return to IDLE, all outputs 0, and any in-flight downstream transfer is dropped.

## Timing
- Upstream setup at cycle 0 → m_psel=1 at cycle 1 → m_penable=1 at cycle 2.
- Zero-wait downstream (m_pready=1 at cycle 2) → s_pready=1 at cycle 3. Upstream therefore sees 2 wait states.
- Each downstream wait state adds one cycle.
- Disabled subsystem: s_pready=1, s_pslverr=1 at cycle 1 (zero upstream wait states).
- Timeout: M_ACCESS lasts exactly TIMEOUT_CYCLES cycles. timeout_o pulses and s_pready=1 in the following (RESP) cycle.
- All outputs are driven from registers or FSM-state decode, with no combinational path from s_* or m_* inputs to outputs.

## Test plan
1. Read, ss_en=1, downstream zero-wait returns 0x1234_5678 → m_psel at cycle 1, m_penable at cycle 2, s_pready=1 at cycle 3 with s_prdata=0x1234_5678, s_pslverr=0.
2. Write addr 0x0105_2004, data 0xA5A5_A5A5, strb 4'b0011, downstream 3 wait states → m_* fields match the request and are stable for 4 access cycles; s_pready at cycle 6, s_pslverr=0.
3. ss_en=0, read → no m_psel at any point; s_pready=1 at cycle 1 with s_pslverr=1 and s_prdata=0xBADC_AB1E.
4. TIMEOUT_CYCLES=4, m_pready tied 0 → m_penable high for 4 cycles then 0; timeout_o pulses once; timeout_cnt_o 0→1; s_pslverr=1 and s_prdata=0xBADC_AB1E. Repeat 300 times with CNT_W=8 → timeout_cnt_o saturates at 255.
5. TIMEOUT_CYCLES=4, m_pready=1 on the 4th access cycle with m_pslverr=1 → no timeout pulse, timeout_cnt_o unchanged, s_pslverr=1 with downstream m_prdata.
6. reset_n asserted during M_ACCESS → all outputs 0 within the same cycle. After release, a fresh zero-wait read completes normally in 3 cycles.
